reg_alarm: RTL and testbench

Alarm-time storage register for the digital watch. It holds the alarm hour and minute, and the alarm second is fixed at zero. While the user holds a set key, the matching field auto-increments once per clock. The outputs go to the alarm comparator and the display mux, alongside the running time counter.

---
 rtl/reg_alarm_if.sv | 25 ++
 rtl/reg_alarm.sv | 36 +++
 tb/tb_reg_alarm.sv | 111 +++++++++++
 3 files changed

// File: rtl/reg_alarm_if.sv
// Alarm register bus: set keys in, alarm time fields out.
// The watch controller is the master; the alarm register is the slave.
interface reg_alarm_if;
    logic       minute_set;
    logic       hour_set;
    logic [5:0] second_data;
    logic [5:0] minute_data;
    logic [5:0] hour_data;

    modport master (
        output minute_set,
        output hour_set,
        input  second_data,
        input  minute_data,
        input  hour_data
    );

    modport slave (
        input  minute_set,
        input  hour_set,
        output second_data,
        output minute_data,
        output hour_data
    );
endinterface

// File: rtl/reg_alarm.sv
// Alarm-time storage: hour and minute fields that auto-increment while their
// set key is held; the alarm second is fixed at zero.
module reg_alarm #(
    parameter int MINUTE_MAX = 59,
    parameter int HOUR_MAX   = 23
) (
    input  logic        clock,
    input  logic        reset,
    reg_alarm_if.slave  bus
);

    logic [5:0] minute;
    logic [5:0] hour;

    // NOTE: state registers use non-blocking assignments so every field
    // updates from the values present before the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            minute <= '0;
            hour   <= '0;
        end else begin
            // Fields wrap independently; a minute wrap never carries into hour.
            if (bus.minute_set) begin
                minute <= (minute == 6'(MINUTE_MAX)) ? '0 : minute + 6'd1;
            end
            if (bus.hour_set) begin
                hour <= (hour == 6'(HOUR_MAX)) ? '0 : hour + 6'd1;
            end
        end
    end

    assign bus.second_data = 6'd0;
    assign bus.minute_data = minute;
    assign bus.hour_data   = hour;

endmodule

// File: tb/tb_reg_alarm.sv
// Self-checking bench for reg_alarm: directed wrap/reset scenarios plus
// randomized set/reset traffic compared against a modular-arithmetic model.
module tb_reg_alarm;

    logic clock = 1'b0;
    logic reset = 1'b0;

    reg_alarm_if bus ();

    reg_alarm #(
        .MINUTE_MAX (59),
        .HOUR_MAX   (23)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: alarm time as plain integers.
    int exp_min = 0;
    int exp_hr  = 0;

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Apply inputs, clock once, advance the model, then compare all outputs.
    task automatic step(input logic r, input logic ms, input logic hs);
        reset          = r;
        bus.minute_set = ms;
        bus.hour_set   = hs;
        @(posedge clock);
        if (r) begin
            exp_min = 0;
            exp_hr  = 0;
        end else begin
            if (ms) exp_min = (exp_min + 1) % 60;
            if (hs) exp_hr  = (exp_hr + 1) % 24;
        end
        #1;
        check("second", bus.second_data, 6'd0);
        check("minute", bus.minute_data, 6'(exp_min));
        check("hour",   bus.hour_data,   6'(exp_hr));
    endtask

    initial begin
        bus.minute_set = 1'b0;
        bus.hour_set   = 1'b0;
        #2;

        // Reset then hold.
        step(1, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0);
        check("hold_min", bus.minute_data, 6'd0);
        check("hold_hr",  bus.hour_data,   6'd0);

        // Minute wrap over 61 clocks.
        for (int i = 0; i < 61; i++) step(0, 1, 0);
        check("min_wrap_end", bus.minute_data, 6'd1);
        check("min_wrap_hr",  bus.hour_data,   6'd0);

        // Hour wrap over 25 clocks; minute left at 1.
        for (int i = 0; i < 25; i++) step(0, 0, 1);
        check("hr_wrap_end", bus.hour_data,   6'd1);
        check("hr_wrap_min", bus.minute_data, 6'd1);

        // Simultaneous set from zero.
        step(1, 0, 0);
        for (int i = 0; i < 24; i++) step(0, 1, 1);
        check("both_hr",  bus.hour_data,   6'd0);
        check("both_min", bus.minute_data, 6'd24);

        // Reset during set once minute reaches 30.
        step(1, 0, 0);
        for (int i = 0; i < 100 && exp_min != 30; i++) step(0, 1, 0);
        check("pre_reset_min", bus.minute_data, 6'd30);
        step(1, 1, 0);
        check("mid_reset_min", bus.minute_data, 6'd0);
        step(0, 1, 0);
        check("post_reset_min", bus.minute_data, 6'd1);

        // Preload 23:59 then hold.
        step(1, 0, 0);
        for (int i = 0; i < 23; i++) step(0, 1, 1);
        for (int i = 0; i < 36; i++) step(0, 1, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0);
        check("preload_hr",  bus.hour_data,   6'd23);
        check("preload_min", bus.minute_data, 6'd59);

        // Randomized traffic; set keys held for bursts, rare resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
